// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, drives the imem address and
// resolves branch/jump/jr redirects with a delay-slot model and stall-time capture.
module if_fetch_unit #(
   parameter int                   PC_WIDTH = 9,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 le,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 jump,
   input  logic [25:0]          jump_addr26,
   input  logic                 jr_taken,
   input  logic [31:0]          jr_target,
   input  logic [31:0]          imem_rdata,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus4,
   output logic [31:0]          instruction_out,
   output logic                 redirect_pending,
   output logic [15:0]          fetch_count
);

   typedef enum logic {RUN, PEND} state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [PC_WIDTH-1:0]  pend_tgt_q, pend_tgt_d;
   logic [15:0]          count_q, count_d;

   logic [PC_WIDTH-1:0]  jump_tgt;
   logic [PC_WIDTH-1:0]  jr_tgt;
   logic [PC_WIDTH-1:0]  br_tgt;
   logic [PC_WIDTH-1:0]  tgt;
   logic                 redirect;
   logic [15:0]          count_inc;
   logic                 unused_bits;

   // Targets are word aligned; the low two bits of every source are dropped.
   assign jump_tgt = {jump_addr26[PC_WIDTH-3:0], 2'b00};
   assign jr_tgt   = {jr_target[PC_WIDTH-1:2], 2'b00};
   assign br_tgt   = {branch_target[PC_WIDTH-1:2], 2'b00};
   assign redirect = jump | jr_taken | branch_taken;

   assign unused_bits = ^{jump_addr26[25:PC_WIDTH-2], jr_target[31:PC_WIDTH],
                          jr_target[1:0], branch_target[1:0]};

   always_comb begin
      tgt = br_tgt;
      if (jump) begin
         tgt = jump_tgt;
      end else if (jr_taken) begin
         tgt = jr_tgt;
      end
   end

   assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      count_d    = count_q;
      unique case (state_q)
         RUN: begin
            if (le) begin
               pc_d    = redirect ? tgt : pc_plus4;
               count_d = count_inc;
            end else if (redirect) begin
               pend_tgt_d = tgt;
               state_d    = PEND;
            end
         end
         PEND: begin
            // A redirect arriving on the release edge is newer than the captured one.
            if (le) begin
               pc_d    = redirect ? tgt : pend_tgt_q;
               count_d = count_inc;
               state_d = RUN;
            end else if (redirect) begin
               pend_tgt_d = tgt;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         pend_tgt_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         count_q    <= count_d;
      end
   end

   assign pc               = pc_q;
   assign pc_plus4         = pc_q + PC_WIDTH'(4);
   assign instruction_out  = imem_rdata;
   assign redirect_pending = (state_q == PEND);
   assign fetch_count      = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

   localparam int PW   = 9;
   localparam int PMOD = 512;

   logic          clk;
   logic          reset;
   logic          le;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          jump;
   logic [25:0]   jump_addr26;
   logic          jr_taken;
   logic [31:0]   jr_target;
   logic [31:0]   imem_rdata;
   logic [PW-1:0] pc;
   logic [PW-1:0] pc_plus4;
   logic [31:0]   instruction_out;
   logic          redirect_pending;
   logic [15:0]   fetch_count;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model state
   int m_pc;
   int m_pend;
   int m_pend_tgt;
   int m_count;

   if_fetch_unit #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset), .le(le),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_addr26(jump_addr26),
      .jr_taken(jr_taken), .jr_target(jr_target),
      .imem_rdata(imem_rdata),
      .pc(pc), .pc_plus4(pc_plus4), .instruction_out(instruction_out),
      .redirect_pending(redirect_pending), .fetch_count(fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int sel_target();
      if (jump)     return (int'(jump_addr26) * 4) % PMOD;
      if (jr_taken) return (int'(jr_target % 32'd512) / 4) * 4;
      return (int'(branch_target) / 4) * 4;
   endfunction

   function automatic void model_reset();
      m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_count = 0;
   endfunction

   function automatic void model_edge();
      int rd;
      rd = int'(jump | jr_taken | branch_taken);
      if (reset) begin
         model_reset();
      end else if (le) begin
         if (rd != 0)       m_pc = sel_target();
         else if (m_pend != 0) m_pc = m_pend_tgt;
         else               m_pc = (m_pc + 4) % PMOD;
         m_pend  = 0;
         m_count = (m_count < 65535) ? m_count + 1 : 65535;
      end else if (rd != 0) begin
         m_pend_tgt = sel_target();
         m_pend     = 1;
      end
   endfunction

   task automatic tick();
      imem_rdata = $urandom;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_redirects();
      branch_taken = 1'b0; jump = 1'b0; jr_taken = 1'b0;
   endtask

   task automatic do_reset();
      clear_redirects();
      le = 1'b0;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_redirects();
      le = 1'b0; branch_target = '0; jump_addr26 = '0; jr_target = '0;
      imem_rdata = 32'hDEAD_BEEF;
      reset = 1'b1;
      model_reset();
      #2;
      n_chk++; if (pc !== 9'd0) $display("FAIL reset_pc got=%0d exp=0", pc); else n_pass++;
      n_chk++; if (pc_plus4 !== 9'd4) $display("FAIL reset_pc_plus4 got=%0d exp=4", pc_plus4); else n_pass++;
      n_chk++; if (redirect_pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", redirect_pending); else n_pass++;
      n_chk++; if (fetch_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", fetch_count); else n_pass++;
      n_chk++; if (instruction_out !== 32'hDEAD_BEEF) $display("FAIL reset_instr got=%h exp=deadbeef", instruction_out); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      do_reset();
      le = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_chk++; if (pc !== 9'(4 * i)) $display("FAIL seq_pc[%0d] got=%0d exp=%0d", i, pc, 4 * i); else n_pass++;
      end
      n_chk++; if (fetch_count !== 16'd4) $display("FAIL seq_count got=%0d exp=4", fetch_count); else n_pass++;
      n_chk++; if (pc_plus4 !== 9'd20) $display("FAIL seq_pc_plus4 got=%0d exp=20", pc_plus4); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      le = 1'b1;
      repeat (127) tick();
      n_chk++; if (pc !== 9'd508) $display("FAIL wrap_pre_pc got=%0d exp=508", pc); else n_pass++;
      n_chk++; if (pc_plus4 !== 9'd0) $display("FAIL wrap_pre_plus4 got=%0d exp=0", pc_plus4); else n_pass++;
      tick();
      n_chk++; if (pc !== 9'd0) $display("FAIL wrap_pc got=%0d exp=0", pc); else n_pass++;
      n_chk++; if (pc_plus4 !== 9'd4) $display("FAIL wrap_plus4 got=%0d exp=4", pc_plus4); else n_pass++;
      n_chk++; if (redirect_pending !== 1'b0) $display("FAIL wrap_pending got=%b exp=0", redirect_pending); else n_pass++;
      n_chk++; if (fetch_count !== 16'd128) $display("FAIL wrap_count got=%0d exp=128", fetch_count); else n_pass++;
   endtask

   task automatic test_branch();
      do_reset();
      le = 1'b1;
      repeat (5) tick();
      n_chk++; if (pc !== 9'd20) $display("FAIL br_start_pc got=%0d exp=20", pc); else n_pass++;
      branch_taken = 1'b1; branch_target = 9'h041;
      tick();
      clear_redirects();
      n_chk++; if (pc !== 9'h040) $display("FAIL br_target_pc got=%h exp=040", pc); else n_pass++;
      tick();
      n_chk++; if (pc !== 9'h044) $display("FAIL br_after_pc got=%h exp=044", pc); else n_pass++;
   endtask

   task automatic test_jump_priority();
      do_reset();
      le = 1'b1;
      repeat (2) tick();
      jump = 1'b1; jump_addr26 = 26'h3;
      jr_taken = 1'b1; jr_target = 32'h100;
      branch_taken = 1'b1; branch_target = 9'h060;
      tick();
      clear_redirects();
      n_chk++; if (pc !== 9'd12) $display("FAIL jump_prio_pc got=%0d exp=12", pc); else n_pass++;
      jr_taken = 1'b1; jr_target = 32'hFFFF_FE83; branch_taken = 1'b1;
      tick();
      clear_redirects();
      n_chk++; if (pc !== 9'h080) $display("FAIL jr_prio_pc got=%h exp=080", pc); else n_pass++;
   endtask

   task automatic test_pend();
      logic [15:0] cnt0;
      do_reset();
      le = 1'b1;
      repeat (2) tick();
      le = 1'b0; jr_taken = 1'b1; jr_target = 32'h100;
      tick();
      clear_redirects();
      cnt0 = fetch_count;
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (redirect_pending !== 1'b1) $display("FAIL pend_flag[%0d] got=%b exp=1", i, redirect_pending); else n_pass++;
         n_chk++; if (pc !== 9'd8) $display("FAIL pend_hold_pc[%0d] got=%0d exp=8", i, pc); else n_pass++;
         tick();
      end
      branch_taken = 1'b1; branch_target = 9'h060;
      tick();
      clear_redirects();
      le = 1'b1;
      tick();
      n_chk++; if (pc !== 9'h060) $display("FAIL pend_release_pc got=%h exp=060", pc); else n_pass++;
      n_chk++; if (redirect_pending !== 1'b0) $display("FAIL pend_release_flag got=%b exp=0", redirect_pending); else n_pass++;
      n_chk++; if (fetch_count !== cnt0 + 16'd1) $display("FAIL pend_release_count got=%0d exp=%0d", fetch_count, cnt0 + 16'd1); else n_pass++;
      // Captured target used when release edge carries no new redirect.
      le = 1'b0; jr_taken = 1'b1; jr_target = 32'h1C4;
      tick();
      clear_redirects();
      le = 1'b1;
      tick();
      n_chk++; if (pc !== 9'h1C4) $display("FAIL pend_captured_pc got=%h exp=1c4", pc); else n_pass++;
      // A redirect on the release edge beats the captured one.
      le = 1'b0; jr_taken = 1'b1; jr_target = 32'h100;
      tick();
      clear_redirects();
      le = 1'b1; jump = 1'b1; jump_addr26 = 26'h20;
      tick();
      clear_redirects();
      n_chk++; if (pc !== 9'h080) $display("FAIL pend_override_pc got=%h exp=080", pc); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      le = 1'b1;
      repeat (3) tick();
      le = 1'b0; branch_taken = 1'b1; branch_target = 9'h100;
      tick();
      clear_redirects();
      n_chk++; if (redirect_pending !== 1'b1) $display("FAIL arst_pre_pending got=%b exp=1", redirect_pending); else n_pass++;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_chk++; if (pc !== 9'd0) $display("FAIL arst_pc got=%0d exp=0", pc); else n_pass++;
      n_chk++; if (redirect_pending !== 1'b0) $display("FAIL arst_pending got=%b exp=0", redirect_pending); else n_pass++;
      n_chk++; if (fetch_count !== 16'd0) $display("FAIL arst_count got=%0d exp=0", fetch_count); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      le = 1'b1;
      tick();
      n_chk++; if (pc !== 9'd4) $display("FAIL arst_after_pc got=%0d exp=4", pc); else n_pass++;
   endtask

   task automatic test_glitch();
      do_reset();
      le = 1'b1;
      tick();
      branch_taken = 1'b1; branch_target = 9'h100;
      #2;
      branch_taken = 1'b0;
      tick();
      n_chk++; if (pc !== 9'd8) $display("FAIL glitch_pc got=%0d exp=8", pc); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         le            = ($urandom_range(0, 3) != 0);
         jump          = ($urandom_range(0, 9) == 0);
         jr_taken      = ($urandom_range(0, 7) == 0);
         branch_taken  = ($urandom_range(0, 5) == 0);
         jump_addr26   = 26'($urandom);
         jr_target     = $urandom;
         branch_target = 9'($urandom);
         tick();
         n_chk++; if (pc !== 9'(m_pc)) $display("FAIL rnd_pc[%0d] got=%0d exp=%0d", i, pc, m_pc); else n_pass++;
         n_chk++; if (pc_plus4 !== 9'((m_pc + 4) % PMOD)) $display("FAIL rnd_plus4[%0d] got=%0d exp=%0d", i, pc_plus4, (m_pc + 4) % PMOD); else n_pass++;
         n_chk++; if (redirect_pending !== 1'(m_pend)) $display("FAIL rnd_pending[%0d] got=%b exp=%0d", i, redirect_pending, m_pend); else n_pass++;
         n_chk++; if (fetch_count !== 16'(m_count)) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, fetch_count, m_count); else n_pass++;
         n_chk++; if (instruction_out !== imem_rdata) $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, instruction_out, imem_rdata); else n_pass++;
      end
      clear_redirects();
   endtask

   task automatic test_saturation();
      do_reset();
      le = 1'b1;
      repeat (65534) tick();
      n_chk++; if (fetch_count !== 16'hFFFE) $display("FAIL sat_pre_count got=%h exp=fffe", fetch_count); else n_pass++;
      repeat (6) tick();
      n_chk++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_count got=%h exp=ffff", fetch_count); else n_pass++;
      n_chk++; if (pc !== 9'(m_pc)) $display("FAIL sat_pc got=%0d exp=%0d", pc, m_pc); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; le = 1'b0; imem_rdata = '0;
      branch_taken = 1'b0; jump = 1'b0; jr_taken = 1'b0;
      branch_target = '0; jump_addr26 = '0; jr_target = '0;
      test_reset();
      test_sequential();
      test_wrap();
      test_branch();
      test_jump_priority();
      test_pend();
      test_async_reset();
      test_glitch();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the program counter and drives the instruction memory address. It sits directly upstream of the IF/ID pipeline register: its `pc` output feeds the IF/ID `input_pc` port, and `instruction_out` feeds the IF/ID `instruction_in` port. It resolves branch, jump and jump-register redirects using a delay-slot model. Redirects that arrive while the pipeline is stalled are captured and applied on release.

## Interface
- `PC_WIDTH`, 9: width of the byte-addressed PC; increments by 4 and wraps modulo 2^PC_WIDTH.
- `RESET_PC`, 0: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `le`  in  1  load enable / advance; 0 = stall, with PC and counter held.
- `branch_taken`  in  1  conditional branch resolved taken this cycle.
- `branch_target`  in  PC_WIDTH  branch destination byte address.
- `jump`  in  1  J/JAL redirect this cycle.
- `jump_addr26`  in  26  instruction [25:0] of the jump.
- `jr_taken`  in  1  register-indirect redirect this cycle.
- `jr_target`  in  32  register value; low PC_WIDTH bits are used.
- `imem_rdata`  in  32  combinational read data for address `pc`.
- `pc`  out  PC_WIDTH  current fetch address; also serves as the imem address.
- `pc_plus4`  out  PC_WIDTH  `pc` + 4, modulo 2^PC_WIDTH.
- `instruction_out`  out  32  equals `imem_rdata` (combinational pass-through).
- `redirect_pending`  out  1  high while in state PEND.
- `fetch_count`  out  16  number of instructions advanced, saturating.

## Operation
- Redirect selection priority: `jump` > `jr_taken` > `branch_taken`.
- Jump target: {jump_addr26[PC_WIDTH-3:0], 2'b00}.
- JR target: jr_target[PC_WIDTH-1:0] with bits [1:0] forced to 0.
- Branch target: branch_target with bits [1:0] forced to 0.
- "redirect" means any of the three redirect inputs is high; "tgt" is the selected target.
- Delay-slot model: the instruction fetched in the cycle a redirect is presented is never squashed. The target takes effect at the next advancing edge.
- The FSM has two states, RUN and PEND. Register `pend_tgt` has width PC_WIDTH.
- RUN, le=1, redirect: pc <= tgt; count++.
- RUN, le=1, no redirect: pc <= pc+4; count++.
- RUN, le=0, redirect: pc held; pend_tgt <= tgt; state <= PEND.
- RUN, le=0, no redirect: everything held.
- PEND, le=0: pc held; a new redirect overwrites pend_tgt; otherwise pend_tgt held.
- PEND, le=1: pc <= (redirect ? tgt : pend_tgt); count++; state <= RUN.
- count++ saturates at 16'hFFFF and does not wrap.
- Reset values: pc = RESET_PC; pc_plus4 = RESET_PC+4; state RUN; redirect_pending = 0; pend_tgt = 0; fetch_count = 0.
- instruction_out reflects imem_rdata at all times, including during reset.

## Timing
- `pc`, `redirect_pending` and `fetch_count` are registered.
- `pc_plus4` and `instruction_out` are combinational from registered `pc` and from `imem_rdata`.
- Redirect latency: a redirect sampled at edge N produces pc = target after edge N, provided le=1 at edge N.
- If le=0 at edge N, the redirect is captured; the target appears after the first later edge with le=1.
- Redirect inputs are sampled only at clock edges. A redirect pulse that is deasserted before the edge has no effect.
- Wrap-around: pc = 2^PC_WIDTH-4 with le=1 and no redirect gives pc = 0. Likewise pc_plus4 wraps to 0.
- Asserting reset mid-PEND discards pend_tgt immediately, without waiting for a clock edge. The first edge after reset deasserts behaves as RUN from RESET_PC.
- Deassertion of reset is synchronous to clk, which is guaranteed externally.

## Test plan
- Reset, then le=1 for 4 cycles -> pc = 0, 4, 8, 12, 16; fetch_count = 4; pc_plus4 = 20.
- Preload pc = 508 (PC_WIDTH=9) and advance with le=1 -> pc = 0, pc_plus4 = 4, no other side effects.
- At pc = 20, assert branch_taken with branch_target = 0x41 and le=1 -> next pc = 0x40, bits [1:0] forced to 0; then pc = 0x44.
- At pc = 8, assert jump with jump_addr26 = 26'h3 and jr_taken together -> jump wins; pc = 12.
- At pc = 8, hold le=0 and pulse jr_taken (jr_target = 0x100) -> redirect_pending = 1 and pc stays 8 for 3 cycles. Then pulse branch (target 0x60) while still stalled, then le=1 -> pc = 0x60, redirect_pending = 0, fetch_count incremented once.
- While in PEND, assert reset asynchronously -> pc = 0, redirect_pending = 0, fetch_count = 0 before the next edge; a later le=1 gives pc = 4.
